// File: rtl/sand_pkg.sv
// rtl/sand_pkg.sv - shared coordinate, mode and drop request types for the sand drop scheduler
package sand_pkg;

    localparam int COORD_W = 9;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        DROP_OFF    = 2'd0,
        DROP_CENTRE = 2'd1,
        DROP_RANDOM = 2'd2,
        DROP_MANUAL = 2'd3
    } drop_mode_e;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } drop_req_t;

    // Pull an out-of-range coordinate back onto the last valid cell; res must be non-zero.
    function automatic coord_t clamp_coord(input coord_t c, input coord_t res);
        return (c >= res) ? coord_t'(res - 1'b1) : c;
    endfunction

endpackage

// File: rtl/sand_drop_fifo.sv
// rtl/sand_drop_fifo.sv - synchronous manual drop request queue, no bypass
module sand_drop_fifo
    import sand_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  drop_req_t push_data_i,
    input  logic      pop_i,
    output drop_req_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);

    drop_req_t       mem_q [DEPTH];
    logic [AW:0]     wptr_q, wptr_d;
    logic [AW:0]     rptr_q, rptr_d;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    // Pointers carry one extra wrap bit so that full and empty stay distinguishable.
    assign count   = wptr_q - rptr_q;
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q + (AW+1)'(do_push);
        rptr_d = rptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/sand_drop_scheduler.sv
// rtl/sand_drop_scheduler.sv - frame strobe generator and per-frame drop source for the sand array
module sand_drop_scheduler
    import sand_pkg::*;
#(
    parameter int          MAX_SIZE     = 32,
    parameter int          COORD_W      = sand_pkg::COORD_W,
    parameter int          FRAME_CYCLES = 416667,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_i,
    input  logic [1:0]         mode_i,
    input  logic [COORD_W-1:0] resolution_i,
    input  logic               manual_valid_i,
    output logic               manual_ready_o,
    input  logic [COORD_W-1:0] manual_x_i,
    input  logic [COORD_W-1:0] manual_y_i,
    output logic               new_frame_o,
    output logic               drop_o,
    output logic [COORD_W-1:0] drop_x_o,
    output logic [COORD_W-1:0] drop_y_o,
    output logic [15:0]        frame_count_o
);

    localparam int               CNT_W    = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam int               PROD_W   = COORD_W + 8;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               new_frame_q, new_frame_d;
    logic               drop_q, drop_d;
    coord_t             drop_x_q, drop_x_d;
    coord_t             drop_y_q, drop_y_d;

    logic               wrap;
    drop_mode_e         mode;
    coord_t             res_eff;
    logic               res_zero;
    logic [PROD_W-1:0]  prod_x, prod_y;
    logic               fifo_full, fifo_empty, fifo_pop;
    drop_req_t          fifo_head, fifo_in;

    assign fifo_in        = '{x: coord_t'(manual_x_i), y: coord_t'(manual_y_i)};
    assign manual_ready_o = !fifo_full;

    sand_drop_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (manual_valid_i),
        .push_data_i(fifo_in),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Resolutions beyond the largest supported grid saturate so drops stay on the array.
    assign res_eff  = (resolution_i > COORD_W'(MAX_SIZE)) ? coord_t'(MAX_SIZE) : coord_t'(resolution_i);
    assign res_zero = (res_eff == '0);
    assign mode     = drop_mode_e'(mode_i);
    assign wrap     = enable_i && (cnt_q == CNT_LAST);
    assign fifo_pop = wrap && (mode == DROP_MANUAL) && !res_zero && !fifo_empty;

    // Scale an 8-bit random fraction onto 0..res-1 without a modulo.
    assign prod_x = PROD_W'(lfsr_q[7:0])  * PROD_W'(res_eff);
    assign prod_y = PROD_W'(lfsr_q[15:8]) * PROD_W'(res_eff);

    always_comb begin
        lfsr_d        = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        cnt_d         = (!enable_i || wrap) ? '0 : cnt_q + 1'b1;
        new_frame_d   = wrap;
        frame_count_d = frame_count_q + 16'(wrap);
        drop_d        = 1'b0;
        drop_x_d      = drop_x_q;
        drop_y_d      = drop_y_q;
        if (wrap && !res_zero) begin
            case (mode)
                DROP_CENTRE: begin
                    drop_d   = 1'b1;
                    drop_x_d = res_eff >> 1;
                    drop_y_d = res_eff >> 1;
                end
                DROP_RANDOM: begin
                    drop_d   = 1'b1;
                    drop_x_d = prod_x[PROD_W-1:8];
                    drop_y_d = prod_y[PROD_W-1:8];
                end
                DROP_MANUAL: begin
                    if (!fifo_empty) begin
                        drop_d   = 1'b1;
                        drop_x_d = clamp_coord(fifo_head.x, res_eff);
                        drop_y_d = clamp_coord(fifo_head.y, res_eff);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            lfsr_q        <= LFSR_SEED;
            frame_count_q <= '0;
            new_frame_q   <= 1'b0;
            drop_q        <= 1'b0;
            drop_x_q      <= '0;
            drop_y_q      <= '0;
        end else begin
            cnt_q         <= cnt_d;
            lfsr_q        <= lfsr_d;
            frame_count_q <= frame_count_d;
            new_frame_q   <= new_frame_d;
            drop_q        <= drop_d;
            drop_x_q      <= drop_x_d;
            drop_y_q      <= drop_y_d;
        end
    end

    assign new_frame_o   = new_frame_q;
    assign drop_o        = drop_q;
    assign drop_x_o      = drop_x_q;
    assign drop_y_o      = drop_y_q;
    assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_sand_drop_scheduler.sv
// tb/tb_sand_drop_scheduler.sv - self-checking bench for the sand drop scheduler
module tb_sand_drop_scheduler;

    localparam int FC = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable_i = 1'b0;
    logic [1:0] mode_i = 2'd0;
    logic [8:0] resolution_i = 9'd32;
    logic       manual_valid_i = 1'b0;
    logic       manual_ready_o;
    logic [8:0] manual_x_i = '0;
    logic [8:0] manual_y_i = '0;
    logic       new_frame_o;
    logic       drop_o;
    logic [8:0] drop_x_o;
    logic [8:0] drop_y_o;
    logic [15:0] frame_count_o;

    sand_drop_scheduler #(
        .MAX_SIZE    (32),
        .COORD_W     (9),
        .FRAME_CYCLES(FC),
        .FIFO_DEPTH  (4),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .mode_i        (mode_i),
        .resolution_i  (resolution_i),
        .manual_valid_i(manual_valid_i),
        .manual_ready_o(manual_ready_o),
        .manual_x_i    (manual_x_i),
        .manual_y_i    (manual_y_i),
        .new_frame_o   (new_frame_o),
        .drop_o        (drop_o),
        .drop_x_o      (drop_x_o),
        .drop_y_o      (drop_y_o),
        .frame_count_o (frame_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_rand;
        bit         drop;
        logic [8:0] x;
        logic [8:0] y;
        logic [8:0] res;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        logic [8:0] res;
        bit         drop;
        logic [8:0] x;
        logic [8:0] y;
        bit         is_rand;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vecs[12];
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] exp_fc = 16'd0;
    logic [8:0]  last_x = '0;
    logic [8:0]  last_y = '0;

    // Reference LFSR: x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form.
    logic [15:0] lfsr_m = 16'hACE1;
    logic [15:0] lfsr_prev = 16'hACE1;
    always @(posedge clk) begin
        lfsr_prev <= lfsr_m;
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    function automatic logic [8:0] scale(input logic [7:0] r, input logic [8:0] res);
        logic [16:0] p;
        p = 17'(r) * 17'(res);
        return p[16:8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    task automatic compare_frame();
        exp_t       e;
        logic [8:0] ex, ey;
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            return;
        end
        e  = exp_q.pop_front();
        ex = e.x;
        ey = e.y;
        if (e.is_rand) begin
            ex = scale(lfsr_prev[7:0], e.res);
            ey = scale(lfsr_prev[15:8], e.res);
        end
        exp_fc = exp_fc + 16'd1;
        if (e.drop) begin
            last_x = ex;
            last_y = ey;
        end
        chk("frame_count", frame_count_o, exp_fc);
        chk("drop", drop_o, e.drop);
        chk("drop_x", drop_x_o, last_x);
        chk("drop_y", drop_y_o, last_y);
    endtask

    task automatic wait_pulse(output int cyc);
        bit seen;
        bit stray;
        seen  = 0;
        stray = 0;
        cyc   = 0;
        while (!seen && cyc < 4 * FC) begin
            @(negedge clk);
            cyc++;
            if (new_frame_o) seen = 1;
            else if (drop_o) stray = 1;
        end
        chk("pulse_seen", seen, 1);
        chk("no_stray_drop", stray, 0);
        if (seen) compare_frame();
    endtask

    task automatic push_req(input logic [8:0] x, input logic [8:0] y, input bit exp_ready);
        manual_valid_i = 1'b1;
        manual_x_i     = x;
        manual_y_i     = y;
        chk("manual_ready", manual_ready_o, exp_ready);
        @(negedge clk);
        manual_valid_i = 1'b0;
    endtask

    task automatic expect_frame(input bit drop, input logic [8:0] x, input logic [8:0] y);
        exp_q.push_back('{is_rand: 1'b0, drop: drop, x: x, y: y, res: 9'd0});
    endtask

    task automatic check_reset_state();
        chk("rst_new_frame", new_frame_o, 0);
        chk("rst_drop", drop_o, 0);
        chk("rst_drop_x", drop_x_o, 0);
        chk("rst_drop_y", drop_y_o, 0);
        chk("rst_frame_count", frame_count_o, 0);
        chk("rst_ready", manual_ready_o, 1);
    endtask

    initial begin
        int cyc;
        logic [8:0] r;

        vecs[0]  = '{2'd0, 9'd32, 1'b0, 9'd0,  9'd0,  1'b0};
        vecs[1]  = '{2'd0, 9'd32, 1'b0, 9'd0,  9'd0,  1'b0};
        vecs[2]  = '{2'd0, 9'd32, 1'b0, 9'd0,  9'd0,  1'b0};
        vecs[3]  = '{2'd1, 9'd32, 1'b1, 9'd16, 9'd16, 1'b0};
        vecs[4]  = '{2'd1, 9'd32, 1'b1, 9'd16, 9'd16, 1'b0};
        vecs[5]  = '{2'd1, 9'd7,  1'b1, 9'd3,  9'd3,  1'b0};
        vecs[6]  = '{2'd1, 9'd7,  1'b1, 9'd3,  9'd3,  1'b0};
        vecs[7]  = '{2'd1, 9'd0,  1'b0, 9'd0,  9'd0,  1'b0};
        vecs[8]  = '{2'd2, 9'd32, 1'b1, 9'd0,  9'd0,  1'b1};
        vecs[9]  = '{2'd2, 9'd32, 1'b1, 9'd0,  9'd0,  1'b1};
        vecs[10] = '{2'd2, 9'd0,  1'b0, 9'd0,  9'd0,  1'b0};
        vecs[11] = '{2'd0, 9'd32, 1'b0, 9'd0,  9'd0,  1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        enable_i = 1'b1;

        for (int i = 0; i < 12; i++) begin
            mode_i       = vecs[i].mode;
            resolution_i = vecs[i].res;
            exp_q.push_back('{is_rand: vecs[i].is_rand, drop: vecs[i].drop,
                              x: vecs[i].x, y: vecs[i].y, res: vecs[i].res});
            wait_pulse(cyc);
            chk("frame_period", cyc, FC);
        end

        mode_i       = 2'd2;
        resolution_i = 9'd32;
        for (int i = 0; i < 1000; i++) begin
            exp_q.push_back('{is_rand: 1'b1, drop: 1'b1, x: 9'd0, y: 9'd0, res: 9'd32});
            wait_pulse(cyc);
            chk("rand_x_range", drop_x_o < 9'd32, 1);
            chk("rand_y_range", drop_y_o < 9'd32, 1);
        end
        for (int i = 0; i < 50; i++) begin
            r = 9'($urandom_range(1, 32));
            resolution_i = r;
            exp_q.push_back('{is_rand: 1'b1, drop: 1'b1, x: 9'd0, y: 9'd0, res: r});
            wait_pulse(cyc);
            chk("rand_var_x_range", drop_x_o < r, 1);
            chk("rand_var_y_range", drop_y_o < r, 1);
        end

        mode_i       = 2'd3;
        resolution_i = 9'd32;
        push_req(9'd5,  9'd9, 1'b1);
        push_req(9'd40, 9'd2, 1'b1);
        push_req(9'd1,  9'd1, 1'b1);
        push_req(9'd2,  9'd2, 1'b1);
        push_req(9'd3,  9'd3, 1'b0);
        expect_frame(1'b1, 9'd5,  9'd9);
        expect_frame(1'b1, 9'd31, 9'd2);
        expect_frame(1'b1, 9'd1,  9'd1);
        expect_frame(1'b1, 9'd2,  9'd2);
        expect_frame(1'b0, 9'd0,  9'd0);
        for (int i = 0; i < 5; i++) wait_pulse(cyc);

        // Push lands exactly in the wrap cycle of an empty queue.
        repeat (FC - 1) @(negedge clk);
        manual_valid_i = 1'b1;
        manual_x_i     = 9'd7;
        manual_y_i     = 9'd8;
        chk("wrap_push_ready", manual_ready_o, 1);
        @(negedge clk);
        manual_valid_i = 1'b0;
        chk("wrap_push_pulse", new_frame_o, 1);
        expect_frame(1'b0, 9'd0, 9'd0);
        compare_frame();
        expect_frame(1'b1, 9'd7, 9'd8);
        wait_pulse(cyc);
        chk("after_wrap_push_period", cyc, FC);

        repeat (4) @(negedge clk);
        enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("disabled_no_pulse", new_frame_o, 0);
        end
        enable_i = 1'b1;
        expect_frame(1'b0, 9'd0, 9'd0);
        wait_pulse(cyc);
        chk("reenable_latency", cyc, FC);

        push_req(9'd4, 9'd4, 1'b1);
        push_req(9'd6, 9'd6, 1'b1);
        push_req(9'd8, 9'd8, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        exp_fc = 16'd0;
        last_x = '0;
        last_y = '0;
        check_reset_state();
        expect_frame(1'b0, 9'd0, 9'd0);
        wait_pulse(cyc);
        chk("post_reset_latency", cyc, FC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
